sprite_row_fetcher: RTL
=======================

// Module: sprite_row_fetcher
// PURPOSE
//  Read-side engine for the 2-bit sprite pixel memory (8192 x 2b, 13-bit address, 1-cycle registered read).
//  Takes one sprite-row request, issues 16 sequential reads and streams out the pixels.
//  Each output pixel carries its screen X and a 2-bit colour.
//  Sits between the sprite scheduler (request side) and the scanline buffer writer (pixel side).
// PARAMETERS
//  X_W              10  width of sprite X / pixel X coordinate
//  SKIP_TRANSPARENT 1   1: colour 2'b00 pixels are dropped, never presented; 0: all 16 presented
// PORTS
//  clk         in   1     system clock; all logic on posedge
//  resetn      in   1     synchronous, active-low reset
//  req_valid   in   1     row request valid
//  req_ready   out  1     engine idle, request accepted when req_valid&&req_ready
//  req_sprite  in   5     sprite index (32 sprites x 256 px)
//  req_row     in   4     sprite row 0..15
//  req_x       in   X_W   screen X of sprite column 0
//  req_flip_x  in   1     mirror columns
//  req_flip_y  in   1     mirror rows
//  mem_ren     out  1     sprite memory read enable
//  mem_raddr   out  13    sprite memory read address
//  mem_rdata   in   2     read data, valid the cycle after mem_ren; held when mem_ren=0
//  pix_valid   out  1     pixel valid
//  pix_ready   in   1     downstream accepts pixel
//  pix_x       out  X_W   pixel screen X
//  pix_color   out  2     pixel colour
//  done        out  1     1-cycle pulse: row fully retired
// BEHAVIOUR
//  Reset: while resetn=0 at a clock edge, all state clears. Outputs stay 0 until the first cycle after release: req_ready, mem_ren, mem_raddr, pix_valid, pix_x, pix_color, done.
//  Reset mid-row: the row is abandoned, any in-flight read is discarded, and the FIFO is emptied.
//  req_ready=1 exactly when state=IDLE.
//  Request fields are latched on accept; later changes on req_* are ignored.
//  States:
//   IDLE  -> FETCH on accept.
//   FETCH -> DRAIN once the 16th read is issued.
//   DRAIN -> IDLE once the last read has returned and the FIFO is empty. done=1 in that cycle.
//  Address = {sprite, row^{4{flip_y}}, col^{4{flip_x}}}, where col counts 0..15.
//  pix_x = req_x + col, computed mod 2^X_W; wrap is allowed and clipping is done downstream.
//  Column order is always ascending pix_x; flip only changes the memory address.
//  Returned data is tagged with its col. It is pushed into a 2-entry output FIFO the cycle it returns.
//  Transparent pixels (SKIP_TRANSPARENT=1) are not pushed, but they still count as retired.
//  Read issue rule: a read is issued in FETCH when (fifo_count + inflight - pop) < 2, where pop = pix_valid&&pix_ready this cycle.
//   This rule guarantees no FIFO overflow and sustains 1 px/cycle.
//  Timing: accept at cycle T. First mem_ren at T+1, first rdata at T+2, first pix_valid at T+3.
//   With pix_ready=1 and no skips, pixels appear on T+3..T+18, done pulses at T+18, and req_ready=1 at T+19.
//  Output handshake: pix_valid, pix_x and pix_color are FIFO head values.
//   While pix_valid=1 and pix_ready=0 they hold stable; pix_valid never drops without a pop.
//  done pulses exactly once per accepted request, including an all-transparent row (no pix_valid at all).
//  A back-to-back request may be accepted only in IDLE; rows never overlap.
//  mem_raddr holds its last value when mem_ren=0.
// TESTING
//  1 Preload sprite 3 row 5 cols=1,2,3,1..; req x=100, no flip, pix_ready=1
//    -> mem_raddr 0x350..0x35F on T+1..T+16; pix_x 100..115 on T+3..T+18 with matching colours; done at T+18.
//  2 sprite 0 row 0, flip_x=flip_y=1
//    -> addresses 0x0FF down to 0x0F0; pix_x still ascending; colours mirrored.
//  3 Request as in 1 with pix_ready random, then held low 5 cycles
//    -> 16 px, none lost or duplicated; outputs stable during stall; FIFO never >2; mem_ren low while full.
//  4 SKIP_TRANSPARENT=1, row 0,1,0,1..
//    -> 8 px at x+1,x+3,...,x+15. All-zero row -> no pix_valid, one done pulse, req_ready returns.
//  5 X_W=10, req_x=1020 -> pix_x 1020..1023 then 0..11.
//  6 resetn low for 1 cycle after 7 px popped
//    -> outputs 0 next cycle; in-flight data not emitted; new request after release fetched correctly from T+1.

Source files
------------

// File: rtl/sprite_row_fetcher_if.sv
// Bus bundle for sprite_row_fetcher.
// Groups three handshakes: the row request from the sprite scheduler, the read
// port of the 8192 x 2b sprite memory, and the pixel stream to the scanline
// buffer writer, plus the end-of-row done pulse.
//   master : scheduler / memory / pixel-sink side (drives req_*, mem_rdata, pix_ready)
//   slave  : the fetch engine (drives req_ready, mem_*, pix_*, done)
interface sprite_row_fetcher_if #(
    parameter int unsigned X_W = 10
);
    logic           req_valid;
    logic           req_ready;
    logic [4:0]     req_sprite;
    logic [3:0]     req_row;
    logic [X_W-1:0] req_x;
    logic           req_flip_x;
    logic           req_flip_y;

    logic           mem_ren;
    logic [12:0]    mem_raddr;
    logic [1:0]     mem_rdata;

    logic           pix_valid;
    logic           pix_ready;
    logic [X_W-1:0] pix_x;
    logic [1:0]     pix_color;

    logic           done;

    modport master (
        output req_valid, req_sprite, req_row, req_x, req_flip_x, req_flip_y,
        output mem_rdata, pix_ready,
        input  req_ready, mem_ren, mem_raddr, pix_valid, pix_x, pix_color, done
    );

    modport slave (
        input  req_valid, req_sprite, req_row, req_x, req_flip_x, req_flip_y,
        input  mem_rdata, pix_ready,
        output req_ready, mem_ren, mem_raddr, pix_valid, pix_x, pix_color, done
    );
endinterface

// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher: read-side engine for the 2-bit sprite pixel memory.
// Accepts one sprite-row request, issues 16 sequential reads to the 1-cycle
// registered sprite memory and streams the returned pixels, tagged with their
// screen X, through a 2-entry output FIFO.
// Ports:
//   clk    : system clock, all logic on posedge
//   resetn : synchronous active-low reset
//   bus    : sprite_row_fetcher_if.slave
//            req_*  row request (sprite, row, x, flips) with valid/ready
//            mem_*  sprite memory read port (ren, 13-bit raddr, 2-bit rdata)
//            pix_*  pixel stream (x, colour) with valid/ready
//            done   1-cycle pulse when a row is fully retired
module sprite_row_fetcher #(
    parameter int unsigned X_W              = 10,
    parameter bit          SKIP_TRANSPARENT = 1'b1
) (
    input logic                 clk,
    input logic                 resetn,
    sprite_row_fetcher_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e state_q, state_d;

    // Latched request
    logic [4:0]     sprite_q;
    logic [3:0]     row_q;
    logic [X_W-1:0] x_q;
    logic           flip_x_q;
    logic           flip_y_q;

    // Next column to issue (always ascending; flip only alters the address)
    logic [3:0]     col_q, col_d;

    // One read can be in flight; its column tags the returned pixel
    logic           inflight_q;
    logic [3:0]     inflight_col_q;
    logic [12:0]    raddr_q;

    // 2-entry output FIFO of {x, colour}
    logic [X_W+1:0] fifo_q [2];
    logic           rd_ptr_q;
    logic           wr_ptr_q;
    logic [1:0]     cnt_q;

    logic           req_ready;
    logic           accept;
    logic           issue;
    logic           push;
    logic           pop;
    logic           done;
    logic           drained;
    logic [2:0]     level;
    logic [12:0]    addr;
    logic [X_W-1:0] push_x;

    assign req_ready = (state_q == StIdle) && resetn;
    assign addr      = {sprite_q, row_q ^ {4{flip_y_q}}, col_q ^ {4{flip_x_q}}};
    assign push_x    = x_q + {{(X_W-4){1'b0}}, inflight_col_q};
    assign pop       = (cnt_q != 2'd0) && bus.pix_ready;
    assign push      = inflight_q && (!SKIP_TRANSPARENT || (bus.mem_rdata != 2'b00));

    // Occupancy the FIFO could reach once the in-flight read lands, after this
    // cycle's pop. Keeping it below 2 before issuing means no overflow.
    assign level     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    // FIFO will be empty after this cycle (no push possible once nothing is in flight)
    assign drained   = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        accept  = 1'b0;
        issue   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready) begin
                    accept  = 1'b1;
                    col_d   = 4'd0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (level < 3'd2) begin
                    issue = 1'b1;
                    col_d = col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q && drained) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= StIdle;
            sprite_q       <= '0;
            row_q          <= '0;
            x_q            <= '0;
            flip_x_q       <= 1'b0;
            flip_y_q       <= 1'b0;
            col_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_col_q <= '0;
            raddr_q        <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            cnt_q          <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            inflight_q <= issue;
            if (accept) begin
                sprite_q <= bus.req_sprite;
                row_q    <= bus.req_row;
                x_q      <= bus.req_x;
                flip_x_q <= bus.req_flip_x;
                flip_y_q <= bus.req_flip_y;
            end
            if (issue) begin
                inflight_col_q <= col_q;
                raddr_q        <= addr;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= {push_x, bus.mem_rdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mem_ren   = issue;
    assign bus.mem_raddr = issue ? addr : raddr_q;
    assign bus.pix_valid = (cnt_q != 2'd0);
    assign bus.pix_x     = fifo_q[rd_ptr_q][X_W+1:2];
    assign bus.pix_color = fifo_q[rd_ptr_q][1:0];
    assign bus.done      = done;
endmodule
